// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
// The package provides the default memory latency, the block geometry and the
// bus widths. It also defines the legacy FSM state encoding and the
// granted-source codes.
package mem_arbiter_pkg;

  localparam int unsigned ARB_MEM_LAT   = 4;
  localparam int unsigned ARB_BLK_WORDS = 8;
  localparam int unsigned ARB_ADDR_W    = 16;
  localparam int unsigned ARB_DATA_W    = 16;
  // Byte-offset bits inside one block (block = 2*BLK_WORDS bytes)
  localparam int unsigned ARB_OFF_W     = $clog2(2 * ARB_BLK_WORDS);
  localparam int unsigned ARB_IDX_W     = (ARB_BLK_WORDS > 1) ? $clog2(ARB_BLK_WORDS) : 1;

  // FSM state encoding (legacy-compatible constants)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL_I = 3'd1;
  localparam logic [2:0] ST_FILL_D = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Which requester owns the current grant
  localparam logic [1:0] SRC_I = 2'd0;
  localparam logic [1:0] SRC_D = 2'd1;
  localparam logic [1:0] SRC_W = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus between the two cache controllers, the memory and the arbiter.
//   slave  : the arbiter's view. Requests and memory read data come in;
//            fill, done/ack and memory command signals go out.
//   master : the environment's view (caches plus memory), the mirror of slave.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
  ;
  logic                  i_miss;
  logic [ARB_ADDR_W-1:0] i_miss_addr;
  logic                  d_miss;
  logic [ARB_ADDR_W-1:0] d_miss_addr;
  logic                  d_wr_req;
  logic [ARB_ADDR_W-1:0] d_wr_addr;
  logic [ARB_DATA_W-1:0] d_wr_data;
  logic                  fill_we;
  logic [ARB_IDX_W-1:0]  fill_idx;
  logic [ARB_DATA_W-1:0] fill_data;
  logic                  fill_sel_d;
  logic                  i_done;
  logic                  d_done;
  logic                  d_wr_ack;
  logic [ARB_ADDR_W-1:0] mem_addr;
  logic [ARB_DATA_W-1:0] mem_wdata;
  logic                  mem_en;
  logic                  mem_wr;
  logic [ARB_DATA_W-1:0] mem_data_in;
  logic                  mem_data_valid;
  logic                  busy;

  modport slave (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_in, mem_data_valid,
    output fill_we, fill_idx, fill_data, fill_sel_d,
    output i_done, d_done, d_wr_ack,
    output mem_addr, mem_wdata, mem_en, mem_wr, busy
  );

  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_in, mem_data_valid,
    input  fill_we, fill_idx, fill_data, fill_sel_d,
    input  i_done, d_done, d_wr_ack,
    input  mem_addr, mem_wdata, mem_en, mem_wr, busy
  );

endinterface

// File: rtl/mem_lat_pipe.sv
// Tag shift register that is DEPTH stages deep.
// A 1 enters on every cycle that issues a fill read. It reaches o_tail on the
// cycle when the data for that read is due back from the memory.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low clear of every stage
//   i_tag  : 1 = a fill read was issued this cycle
//   o_tail : the tag issued DEPTH cycles ago
module mem_lat_pipe #(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tag,
  output logic o_tail
);

  logic [DEPTH-1:0] r_tags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tags <= '0;
    end else begin
      r_tags[0] <= i_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_tags[i] <= r_tags[i-1];
      end
    end
  end

  assign o_tail = r_tags[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single unified memory.
// Three requesters share the memory: the I-cache miss path, the D-cache miss
// path and the D-side write-through stores. Each cache miss becomes a block
// fill of BLK_WORDS words. The fill issues one read per cycle to a pipelined
// memory with a fixed latency. A store becomes one write cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave. It carries the requests, fills, done/ack
//           pulses, the memory command/data and busy.
// The interface widths must match the ADDR_W/DATA_W/BLK_WORDS values used here.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT   = ARB_MEM_LAT,
  parameter int unsigned BLK_WORDS = ARB_BLK_WORDS,
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned DATA_W    = ARB_DATA_W
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned OFF_W = $clog2(2 * BLK_WORDS);
  localparam int unsigned IDX_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(BLK_WORDS + 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  logic [2:0]        r_state;
  logic [1:0]        r_src;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_rx_cnt;

  logic w_in_fill;
  logic w_issue;
  logic w_tail;
  logic w_fill_we;

  assign w_in_fill = (r_state == ST_FILL_I) || (r_state == ST_FILL_D);
  assign w_issue   = w_in_fill && (r_issue_cnt < CNT_W'(BLK_WORDS));
  // A valid from memory counts only when it lines up with one of our own
  // reads. Stray valids, and returns from before a reset, are dropped.
  assign w_fill_we = w_in_fill && w_tail && bus.mem_data_valid;

  mem_lat_pipe #(
    .DEPTH (MEM_LAT)
  ) u_lat_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_tag  (w_issue),
    .o_tail (w_tail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_src       <= SRC_I;
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_rx_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_issue_cnt <= '0;
          r_rx_cnt    <= '0;
          if (bus.d_wr_req) begin
            r_state <= ST_WRITE;
            r_src   <= SRC_W;
          end else if (bus.d_miss) begin
            r_state <= ST_FILL_D;
            r_src   <= SRC_D;
            r_base  <= bus.d_miss_addr & BASE_MASK;
          end else if (bus.i_miss) begin
            r_state <= ST_FILL_I;
            r_src   <= SRC_I;
            r_base  <= bus.i_miss_addr & BASE_MASK;
          end
        end
        ST_WRITE: begin
          r_state <= ST_DONE;
        end
        ST_FILL_I, ST_FILL_D: begin
          if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          if (w_fill_we) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_cnt == CNT_W'(BLK_WORDS - 1)) begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (r_state == ST_WRITE) begin
      bus.mem_en    = 1'b1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = bus.d_wr_addr;
      bus.mem_wdata = bus.d_wr_data;
    end else if (w_issue) begin
      bus.mem_en   = 1'b1;
      // The sum is truncated to ADDR_W bits, so the address wraps at the top
      // of memory.
      bus.mem_addr = r_base + (ADDR_W'(r_issue_cnt) << 1);
    end
  end

  assign bus.fill_we    = w_fill_we;
  assign bus.fill_idx   = r_rx_cnt[IDX_W-1:0];
  assign bus.fill_data  = bus.mem_data_in;
  // Stays high through DONE, so the D-cache still sees its selection on the
  // done cycle.
  assign bus.fill_sel_d = (r_state == ST_FILL_D) || ((r_state == ST_DONE) && (r_src == SRC_D));
  assign bus.i_done     = (r_state == ST_DONE) && (r_src == SRC_I);
  assign bus.d_done     = (r_state == ST_DONE) && (r_src == SRC_D);
  assign bus.d_wr_ack   = (r_state == ST_DONE) && (r_src == SRC_W);
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MEM_LAT   (ARB_MEM_LAT),
    .BLK_WORDS (ARB_BLK_WORDS),
    .ADDR_W    (ARB_ADDR_W),
    .DATA_W    (ARB_DATA_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } mem_rsp_t;

  typedef struct {
    int          due;
    logic [15:0] data;
    logic [2:0]  idx;
    logic        sel;
  } fill_exp_t;

  typedef struct {
    logic        sel_d;
    logic [15:0] addr;
    logic [15:0] exp_base;
  } fill_vec_t;

  mem_rsp_t  mq[$];
  fill_exp_t sb[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_fill  = 0;
  logic exp_sel_d   = 1'b0;
  logic force_valid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model: the data for a read is its address XOR a constant and it
  // returns MEM_LAT cycles after the read is issued. Each read also pushes
  // its expected fill word onto the scoreboard.
  task automatic monitor();
    logic [15:0] d;
    if (bus.mem_en && !bus.mem_wr) begin
      d = bus.mem_addr ^ 16'hA5C3;
      mq.push_back('{due: cyc + ARB_MEM_LAT, data: d});
      sb.push_back('{due: cyc + ARB_MEM_LAT, data: d, idx: bus.mem_addr[3:1], sel: exp_sel_d});
    end
    if (bus.fill_we) begin
      n_fill++;
      if (sb.size() == 0 || sb[0].due != cyc) begin
        chk("fill_unexpected", 64'(bus.fill_we), 64'd0);
      end else begin
        chk("fill_data", 64'(bus.fill_data), 64'(sb[0].data));
        chk("fill_idx", 64'(bus.fill_idx), 64'(sb[0].idx));
        chk("fill_sel_d", 64'(bus.fill_sel_d), 64'(sb[0].sel));
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("fill_missing", 64'(bus.fill_we), 64'd1);
      void'(sb.pop_front());
    end
  endtask

  // Advance one cycle: drive the memory response just after the rising edge,
  // then sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = mq[0].data;
      void'(mq.pop_front());
    end else if (force_valid) begin
      bus.mem_data_valid = 1'b1;
      bus.mem_data_in    = 16'hDEAD;
    end else begin
      bus.mem_data_valid = 1'b0;
      bus.mem_data_in    = '0;
    end
    @(negedge clk);
    monitor();
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.fill_we, bus.fill_idx, bus.fill_data, bus.fill_sel_d, bus.i_done, bus.d_done,
            bus.d_wr_ack, bus.mem_addr, bus.mem_wdata, bus.mem_en, bus.mem_wr, bus.busy};
  endfunction

  // Tick until the selected done pulse (0 = I, 1 = D). The request is dropped
  // on the done cycle. rel is the number of ticks taken, or -1 on timeout.
  task automatic wait_done(input logic which, input int budget, output int rel);
    rel = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if ((which == 1'b0 && bus.i_done) || (which == 1'b1 && bus.d_done)) begin
        rel = k;
        if (which) bus.d_miss = 1'b0;
        else bus.i_miss = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_fill(input logic sel_d, input logic [15:0] addr, input logic [15:0] base);
    int rel, done_rel, n_own, n_wrong, first_f, last_f, fills0, en_after;
    logic own;
    rel = 0; done_rel = -1; n_own = 0; n_wrong = 0; first_f = -1; last_f = -1; en_after = 0;
    fills0 = n_fill;
    exp_sel_d = sel_d;
    if (sel_d) begin bus.d_miss = 1'b1; bus.d_miss_addr = addr; end
    else begin bus.i_miss = 1'b1; bus.i_miss_addr = addr; end
    while (rel < 40) begin
      tick();
      rel++;
      if (rel <= 8) begin
        chk("rd_cmd", 64'({bus.mem_en, bus.mem_wr}), 64'(2'b10));
        chk("rd_addr", 64'(bus.mem_addr), 64'(16'(base + 16'(2 * (rel - 1)))));
      end else if (bus.mem_en) begin
        en_after++;
      end
      if (bus.fill_we) begin
        if (first_f < 0) first_f = rel;
        last_f = rel;
      end
      if (done_rel >= 0) begin
        chk("idle_after_done", 64'(bus.busy), 64'd0);
        break;
      end
      own = sel_d ? bus.d_done : bus.i_done;
      if ((sel_d ? bus.i_done : bus.d_done) || bus.d_wr_ack) n_wrong++;
      if (own) begin
        n_own++;
        done_rel = rel;
        chk("sel_held_in_done", 64'(bus.fill_sel_d), 64'(sel_d));
        if (sel_d) bus.d_miss = 1'b0;
        else bus.i_miss = 1'b0;
      end
    end
    chk("done_cycle", 64'(done_rel), 64'd13);
    chk("done_count", 64'(n_own), 64'd1);
    chk("wrong_done", 64'(n_wrong), 64'd0);
    chk("first_fill", 64'(first_f), 64'd5);
    chk("last_fill", 64'(last_f), 64'd12);
    chk("fill_count", 64'(n_fill - fills0), 64'd8);
    chk("extra_mem_en", 64'(en_after), 64'd0);
  endtask

  initial begin
    fill_vec_t vecs[5];
    int rel, ack_rel, dd_rel, id_rel, r, fills0;

    vecs[0] = '{sel_d: 1'b0, addr: 16'h1234, exp_base: 16'h1230};
    vecs[1] = '{sel_d: 1'b1, addr: 16'hFFFA, exp_base: 16'hFFF0};
    vecs[2] = '{sel_d: 1'b0, addr: 16'h0000, exp_base: 16'h0000};
    vecs[3] = '{sel_d: 1'b1, addr: 16'h800F, exp_base: 16'h8000};
    vecs[4] = '{sel_d: 1'b0, addr: 16'h7FF1, exp_base: 16'h7FF0};

    rst_n = 1'b0;
    bus.i_miss = 1'b0; bus.i_miss_addr = '0; bus.d_miss = 1'b0; bus.d_miss_addr = '0;
    bus.d_wr_req = 1'b0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
    bus.mem_data_in = '0; bus.mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 64'(bus.busy), 64'd0);

    // Table-driven single fills
    for (int i = 0; i < 5; i++) begin
      run_fill(vecs[i].sel_d, vecs[i].addr, vecs[i].exp_base);
      tick();
    end

    // Priority: write first, then the D fill, then the I fill
    exp_sel_d = 1'b1;
    bus.d_wr_req = 1'b1; bus.d_wr_addr = 16'h0040; bus.d_wr_data = 16'hBEEF;
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h2006;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h301C;
    tick();
    chk("wr_cmd", 64'({bus.mem_en, bus.mem_wr, bus.busy}), 64'(3'b111));
    chk("wr_addr", 64'(bus.mem_addr), 64'h0040);
    chk("wr_data", 64'(bus.mem_wdata), 64'hBEEF);
    rel = 1; ack_rel = -1; dd_rel = -1; id_rel = -1;
    while (rel < 80 && id_rel < 0) begin
      tick();
      rel++;
      if (rel == 3) chk("idle_between", 64'(bus.busy), 64'd0);
      if (rel == 4) chk("d_first_addr", 64'({bus.fill_sel_d, bus.mem_addr}), 64'({1'b1, 16'h2000}));
      if (rel == 18) chk("i_first_addr", 64'({bus.fill_sel_d, bus.mem_addr}), 64'({1'b0, 16'h3010}));
      if (bus.d_wr_ack) begin ack_rel = rel; bus.d_wr_req = 1'b0; end
      if (bus.d_done) begin dd_rel = rel; bus.d_miss = 1'b0; exp_sel_d = 1'b0; end
      if (bus.i_done) begin id_rel = rel; bus.i_miss = 1'b0; end
    end
    chk("wr_ack_cycle", 64'(ack_rel), 64'd2);
    chk("d_done_cycle", 64'(dd_rel), 64'd16);
    chk("i_done_cycle", 64'(id_rel), 64'd30);
    tick();
    chk("idle_after_prio", 64'(bus.busy), 64'd0);

    // Reset in the middle of a fill: the stale returns must be ignored
    exp_sel_d = 1'b0;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h1234;
    repeat (3) tick();
    rst_n = 1'b0;
    sb.delete();
    bus.i_miss_addr = 16'h5678;
    tick();
    chk("midfill_reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    fills0 = n_fill;
    tick();
    chk("post_reset_addr", 64'({bus.mem_en, bus.mem_addr}), 64'({1'b1, 16'h5670}));
    wait_done(1'b0, 40, r);
    chk("post_reset_done", 64'(r), 64'd12);
    chk("post_reset_fills", 64'(n_fill - fills0), 64'd8);
    tick();

    // A stray valid while IDLE must not fill or start anything
    force_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("idle_valid", 64'({bus.fill_we, bus.busy}), 64'd0);
    end
    force_valid = 1'b0;
    tick();

    // Back-to-back: I miss raised again on the IDLE cycle after i_done
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0102;
    wait_done(1'b0, 40, r);
    chk("b2b_first_done", 64'(r), 64'd13);
    tick();
    chk("b2b_idle_gap", 64'(bus.busy), 64'd0);
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0A0E;
    tick();
    chk("b2b_second_start", 64'({bus.busy, bus.mem_addr}), 64'({1'b1, 16'h0A00}));
    wait_done(1'b0, 40, r);
    chk("b2b_second_done", 64'(r), 64'd12);
    tick();
    chk("b2b_idle_end", 64'(bus.busy), 64'd0);
    repeat (6) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
